edge_detection: RTL and testbench
=================================

Name: edge_detection

Overview:
- Per-cycle rising/falling/any-edge detector for one or more level signals, all in a single clock domain.
- Sits directly behind a debouncer or synchronizer stage. It converts a slow level into single-cycle strobes for downstream counters and FSMs.
- An optional input synchronizer chain and an optional output register are selectable by parameter.

Parameters:
- WIDTH, 1, number of independent level channels; legal range 1..32.
- SYNC_STAGES, 0, flops inserted on level before detection; 0 = level assumed already synchronous; legal range 0..4.
- REGISTERED_OUT, 0, 0 = Mealy outputs (combinational from level and history); 1 = outputs registered (one extra cycle of latency).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset; one clock; reset is synchronous and active-high.
- level  in  WIDTH  level input(s) to monitor.
- p_edge  out  WIDTH  one-cycle strobe on a 0->1 transition of the corresponding channel.
- n_edge  out  WIDTH  one-cycle strobe on a 1->0 transition.
- edge_  out  WIDTH  p_edge | n_edge, per channel.

Behaviour:
- Internal signal s = level delayed by SYNC_STAGES flops (s = level when SYNC_STAGES = 0).
- History register h <= s every clk.
- Detection terms (per bit): pe = s & ~h; ne = ~s & h; ae = s ^ h.
- REGISTERED_OUT = 0:
  - p_edge = pe, n_edge = ne, edge_ = ae, gated to 0 while reset_n = 1.
  - The strobe is visible in the same cycle s changes, and lasts exactly one cycle.
- REGISTERED_OUT = 1: outputs are flops loaded with pe/ne/ae; strobe appears one clk after s changes, one cycle wide.
- Total latency from a level change to the strobe = SYNC_STAGES + REGISTERED_OUT clocks, with the REGISTERED_OUT = 0 strobe combinational in its detection cycle.
- Reset (reset_n = 1 sampled at clk rising edge):
  - All sync flops, h, and output flops clear to 0.
  - All outputs read 0 for the whole reset period, including the Mealy outputs through the gating.
- Level undefined (X) or asserted during reset: no effect; history stays 0.
- First cycle after reset with s = 1: p_edge and edge_ assert for one cycle, because history is 0. This is intended.
- Reset asserted mid-strobe: the strobe is cut off at that clock and history clears.
- Level held constant: all outputs stay 0 indefinitely.
- Level toggling every cycle: edge_ stays high continuously; p_edge and n_edge alternate each cycle.
- Channels are fully independent; there is no cross-channel interaction.
- p_edge & n_edge is never 1 on the same bit. A property check enforces this.
- No handshake; outputs are pure strobes with no hold or acknowledge.

Decomposition:
- Shared package edge_pkg holds:
  - constant MAX_SYNC_STAGES = 4;
  - constant MAX_WIDTH = 32;
  - a typedef for the per-channel edge-type encoding {NONE, RISE, FALL}, used by bench scoreboards.
- One sub-module, sync_chain (WIDTH, STAGES):
  - a reset-cleared shift register;
  - generates a pass-through when STAGES = 0.
- Detection logic and the output register stay in edge_detection.
- Parameter legality is checked at elaboration: fatal if WIDTH or SYNC_STAGES is out of range.

Test Plan:
- Defaults, reset 1 for 1 cycle, then level = 0 and toggled every negedge for 100 cycles -> after the first rise, edge_ = 1 every cycle; p_edge = 1 on cycles where level = 1; n_edge = 1 where level = 0; p_edge & n_edge never both 1.
- Defaults, level = 1 held through reset, reset released -> p_edge = 1 and edge_ = 1 for exactly the first post-reset cycle, then all 0.
- Defaults, level 0 -> 1 held 10 cycles -> 1 -> 0 -> exactly one p_edge pulse and one n_edge pulse, each 1 cycle wide.
- SYNC_STAGES = 2, REGISTERED_OUT = 1, single rise -> p_edge asserts exactly 3 clocks after the level change, 1 cycle wide.
- WIDTH = 4, level = 4'b0000 -> 4'b0101 -> 4'b1100 on consecutive cycles:
  - p_edge = 4'b0101, then 4'b1000;
  - n_edge = 4'b0000, then 4'b0001;
  - edge_ = 4'b0101, then 4'b1001.
- Reset asserted in the cycle of a rising edge -> outputs 0 in that cycle; history cleared; a level still high after release yields a fresh p_edge pulse.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared constants and the per-channel edge classification used around edge_detection.
package edge_pkg;

  localparam int MAX_SYNC_STAGES = 4;
  localparam int MAX_WIDTH       = 32;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2
  } edge_type_e;

endpackage

// File: rtl/sync_chain.sv
// Reset-cleared shift register of STAGES flops per bit; a plain wire when STAGES = 0.
module sync_chain
  import edge_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES == 0) begin : g_bypass
    // clk/reset_n have no load in the bypass build
    logic unused_ctrl;
    assign unused_ctrl = clk ^ reset_n;
    assign q = d;
  end else begin : g_chain
    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
      if (reset_n) begin
        for (int i = 0; i < STAGES; i++) stage[i] <= '0;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[STAGES-1];
  end

endmodule

// File: rtl/edge_detection.sv
// Per-channel rising/falling/any-edge strobes from slow levels, with optional
// input synchronizer and optional registered outputs. reset_n is active-high.
module edge_detection
  import edge_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int SYNC_STAGES    = 0,
  parameter int REGISTERED_OUT = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] p_edge,
  output logic [WIDTH-1:0] n_edge,
  output logic [WIDTH-1:0] edge_
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "edge_detection: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
    $fatal(1, "edge_detection: SYNC_STAGES %0d outside 0..%0d", SYNC_STAGES, MAX_SYNC_STAGES);
  end
  if (REGISTERED_OUT != 0 && REGISTERED_OUT != 1) begin : g_bad_reg
    $fatal(1, "edge_detection: REGISTERED_OUT %0d must be 0 or 1", REGISTERED_OUT);
  end

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] h;
  logic [WIDTH-1:0] pe, ne, ae;

  sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (level),
    .q       (s)
  );

  always_ff @(posedge clk) begin
    if (reset_n) h <= '0;
    else         h <= s;
  end

  assign pe = s & ~h;
  assign ne = ~s & h;
  assign ae = s ^ h;

  if (REGISTERED_OUT != 0) begin : g_reg_out
    always_ff @(posedge clk) begin
      if (reset_n) begin
        p_edge <= '0;
        n_edge <= '0;
        edge_  <= '0;
      end else begin
        p_edge <= pe;
        n_edge <= ne;
        edge_  <= ae;
      end
    end
  end else begin : g_comb_out
    // gating keeps the Mealy path quiet while reset is held, even with X on level
    assign p_edge = reset_n ? '0 : pe;
    assign n_edge = reset_n ? '0 : ne;
    assign edge_  = reset_n ? '0 : ae;
  end

  a_no_dual_edge : assert property (@(posedge clk) disable iff (reset_n)
    (p_edge & n_edge) == '0);

endmodule

// File: tb/tb_edge_detection.sv
// Directed checks of edge_detection in default, synchronized+registered and 4-bit builds.
module tb_edge_detection;
  import edge_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [0:0] lvl;
  logic [0:0] p_d, n_d, e_d;
  logic [0:0] lvl_s;
  logic [0:0] p_s, n_s, e_s;
  logic [3:0] lvl_w;
  logic [3:0] p_w, n_w, e_w;

  int checks   = 0;
  int failures = 0;

  edge_detection dut_def (
    .clk(clk), .reset_n(reset_n), .level(lvl),
    .p_edge(p_d), .n_edge(n_d), .edge_(e_d)
  );

  edge_detection #(.WIDTH(1), .SYNC_STAGES(2), .REGISTERED_OUT(1)) dut_sync (
    .clk(clk), .reset_n(reset_n), .level(lvl_s),
    .p_edge(p_s), .n_edge(n_s), .edge_(e_s)
  );

  edge_detection #(.WIDTH(4)) dut_w4 (
    .clk(clk), .reset_n(reset_n), .level(lvl_w),
    .p_edge(p_w), .n_edge(n_w), .edge_(e_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b1;
    lvl = 1'b0; lvl_s = 1'b0; lvl_w = 4'b0000;
    @(negedge clk);
    reset_n = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    lvl = 1'bx;
    #1;
    checks++;
    if ({p_d, n_d, e_d} !== 3'b000) begin
      failures++;
      $display("FAIL reset_x_level: got p/n/e=%b%b%b expected 000", p_d, n_d, e_d);
    end
    @(negedge clk);
    lvl = 1'b1;
    #1;
    checks++;
    if ({p_d, n_d, e_d} !== 3'b000) begin
      failures++;
      $display("FAIL reset_level_high: got p/n/e=%b%b%b expected 000", p_d, n_d, e_d);
    end
    checks++;
    if ({p_s, n_s, e_s, p_w, n_w, e_w} !== 15'b0) begin
      failures++;
      $display("FAIL reset_other_duts: got sync=%b%b%b w4=%b/%b/%b expected all 0",
               p_s, n_s, e_s, p_w, n_w, e_w);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({p_d, n_d, e_d} !== 3'b101) begin
      failures++;
      $display("FAIL first_cycle_after_reset: got p/n/e=%b%b%b expected 101", p_d, n_d, e_d);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({p_d, n_d, e_d} !== 3'b000) begin
        failures++;
        $display("FAIL held_high_after_reset[%0d]: got p/n/e=%b%b%b expected 000", k, p_d, n_d, e_d);
      end
    end
  endtask

  task automatic test_toggle();
    logic       prev;
    edge_type_e et;
    do_reset();
    prev = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      lvl = ~lvl;
      #1;
      et = (lvl && !prev) ? RISE : ((!lvl && prev) ? FALL : NONE);
      checks++;
      if (p_d !== (et == RISE) || n_d !== (et == FALL) || e_d !== 1'b1) begin
        failures++;
        $display("FAIL toggle[%0d]: got p/n/e=%b%b%b expected %b%b1", c, p_d, n_d, e_d,
                 et == RISE, et == FALL);
      end
      if ((p_d & n_d) !== 1'b0) begin
        failures++;
        $display("FAIL toggle_dual[%0d]: p and n both high", c);
      end
      prev = lvl;
    end
  endtask

  task automatic test_hold();
    int np, nn, pw, nw;
    do_reset();
    np = 0; nn = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) lvl = 1'b1;
      else if (c == 11) lvl = 1'b0;
      #1;
      if (p_d === 1'b1) np++;
      if (n_d === 1'b1) nn++;
      pw = (c == 0) ? 1 : 0;
      nw = (c == 11) ? 1 : 0;
      checks++;
      if (p_d !== pw[0] || n_d !== nw[0] || e_d !== (pw[0] | nw[0])) begin
        failures++;
        $display("FAIL hold[%0d]: got p/n/e=%b%b%b expected %b%b%b", c, p_d, n_d, e_d,
                 pw[0], nw[0], pw[0] | nw[0]);
      end
    end
    checks++;
    if (np != 1 || nn != 1) begin
      failures++;
      $display("FAIL hold_pulse_count: got p=%0d n=%0d expected 1 1", np, nn);
    end
  endtask

  task automatic test_sync_registered();
    do_reset();
    @(negedge clk);
    lvl_s = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (p_s !== (k == 3) || e_s !== (k == 3) || n_s !== 1'b0) begin
        failures++;
        $display("FAIL sync_latency[clk %0d]: got p/n/e=%b%b%b expected %b0%b", k, p_s, n_s, e_s,
                 k == 3, k == 3);
      end
    end
  endtask

  task automatic test_width4();
    do_reset();
    @(negedge clk);
    lvl_w = 4'b0000;
    @(negedge clk);
    lvl_w = 4'b0101;
    #1;
    checks++;
    if (p_w !== 4'b0101 || n_w !== 4'b0000 || e_w !== 4'b0101) begin
      failures++;
      $display("FAIL w4_step1: got p=%b n=%b e=%b expected 0101 0000 0101", p_w, n_w, e_w);
    end
    @(negedge clk);
    lvl_w = 4'b1100;
    #1;
    checks++;
    if (p_w !== 4'b1000 || n_w !== 4'b0001 || e_w !== 4'b1001) begin
      failures++;
      $display("FAIL w4_step2: got p=%b n=%b e=%b expected 1000 0001 1001", p_w, n_w, e_w);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({p_w, n_w, e_w} !== 12'b0) begin
      failures++;
      $display("FAIL w4_hold: got p=%b n=%b e=%b expected all 0", p_w, n_w, e_w);
    end
  endtask

  task automatic test_reset_mid_edge();
    do_reset();
    @(negedge clk);
    lvl = 1'b1;
    reset_n = 1'b1;
    #1;
    checks++;
    if ({p_d, n_d, e_d} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid_edge: got p/n/e=%b%b%b expected 000", p_d, n_d, e_d);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({p_d, n_d, e_d} !== 3'b101) begin
      failures++;
      $display("FAIL reset_mid_fresh_pulse: got p/n/e=%b%b%b expected 101", p_d, n_d, e_d);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({p_d, n_d, e_d} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid_pulse_width: got p/n/e=%b%b%b expected 000", p_d, n_d, e_d);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    lvl = 1'b0; lvl_s = 1'b0; lvl_w = 4'b0000;
    repeat (2) @(posedge clk);
    test_reset();
    test_toggle();
    test_hold();
    test_sync_registered();
    test_width4();
    test_reset_mid_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
